spw_tx_fifo_reader: RTL and testbench

Read-side consumer for the SpaceWire transmit FIFO. It pops 9-bit N-Char entries from the FIFO's read port, absorbs the FIFO's one-cycle read latency in a 2-entry prefetch buffer, and presents the entries to the transmit encoder on a valid/ready handshake. It also counts transmitted EOP/EEP markers and supports a flush that discards the rest of the current packet. It sits between the FIFO read port, in the `rdclk` domain, and the TX character encoder.

---
 rtl/spw_tx_fifo_reader.sv | 147 ++++++++++++++
 tb/tb_spw_tx_fifo_reader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spw_tx_fifo_reader.sv
// spw_tx_fifo_reader
// Read-side consumer of the SpaceWire transmit FIFO. Pops N-Chars from the
// FIFO read port, hides the one-cycle FIFO read latency behind a 2-entry
// prefetch buffer and hands the entries to the TX encoder over valid/ready.
// Counts transferred EOP/EEP markers and can flush the rest of a packet.
//
// State table
//   state | meaning
//   IDLE  | no reads issued; buffered entries (if any) still presented
//   RUN   | prefetching from the FIFO and presenting entries
//   FLUSH | buffer cleared; reading and discarding up to the next EOP/EEP
//
// Ports
//   rdclk, rd_rst          clock and synchronous active-high reset
//   enable                 permits new FIFO reads
//   flush                  single-cycle pulse: drop rest of current packet
//   fifo_q, fifo_rdempty   FIFO read data (one cycle after rdreq) and empty
//   fifo_rdreq             FIFO pop request (combinational)
//   tx_data/valid/ready    N-Char handshake towards the encoder
//   eop_count, eep_count   wrapping counts of transferred EOP/EEP
//   busy                   state not IDLE, or buffer/inflight occupied
module spw_tx_fifo_reader #(
   parameter int DATA_SIZE = 9,
   parameter int CNT_SIZE  = 16
) (
   input  logic                 rdclk,
   input  logic                 rd_rst,
   input  logic                 enable,
   input  logic                 flush,
   input  logic [DATA_SIZE-1:0] fifo_q,
   input  logic                 fifo_rdempty,
   output logic                 fifo_rdreq,
   output logic [DATA_SIZE-1:0] tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic [CNT_SIZE-1:0]  eop_count,
   output logic [CNT_SIZE-1:0]  eep_count,
   output logic                 busy
);

   localparam logic [DATA_SIZE-1:0] N_EOP = DATA_SIZE'(9'h100);
   localparam logic [DATA_SIZE-1:0] N_EEP = DATA_SIZE'(9'h101);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [1:0]           occ_q, occ_d;
   logic                 inflight_q, inflight_d;
   logic [DATA_SIZE-1:0] buf0_q, buf0_d;   // head entry
   logic [DATA_SIZE-1:0] buf1_q, buf1_d;
   logic [CNT_SIZE-1:0]  eop_q, eop_d;
   logic [CNT_SIZE-1:0]  eep_q, eep_d;

   logic                 pop;
   logic                 marker_in;
   logic [1:0]           level;
   logic [1:0]           wr_idx;

   always_comb begin
      state_d    = state_q;
      occ_d      = occ_q;
      buf0_d     = buf0_q;
      buf1_d     = buf1_q;
      eop_d      = eop_q;
      eep_d      = eep_q;
      fifo_rdreq = 1'b0;

      tx_valid  = (occ_q != 2'd0);
      tx_data   = buf0_q;
      pop       = tx_valid && tx_ready;
      marker_in = inflight_q && ((fifo_q == N_EOP) || (fifo_q == N_EEP));
      // Occupancy after this cycle's pop, counting the entry still in flight.
      level     = occ_q + {1'b0, inflight_q} - {1'b0, pop};
      wr_idx    = occ_q - {1'b0, pop};

      if (pop) begin
         if (buf0_q == N_EOP) eop_d = eop_q + CNT_SIZE'(1);
         if (buf0_q == N_EEP) eep_d = eep_q + CNT_SIZE'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            if (enable) state_d = S_RUN;
         end
         S_RUN: begin
            fifo_rdreq = enable && !fifo_rdempty && (level < 2'd2);
            if (!enable && (occ_q == 2'd0) && !inflight_q) state_d = S_IDLE;
         end
         S_FLUSH: begin
            // One read per two cycles: each entry is inspected before the next.
            fifo_rdreq = !fifo_rdempty && !inflight_q;
            if (marker_in) state_d = enable ? S_RUN : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (state_q != S_FLUSH) begin
         if (pop) buf1_d = buf1_q;
         if (pop) buf0_d = buf1_q;
         if (inflight_q) begin
            if (wr_idx == 2'd0) buf0_d = fifo_q;
            else                buf1_d = fifo_q;
         end
         occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};

         // Any transfer in this cycle still completes; the buffer is dropped
         // afterwards. An entry arriving now is treated as already flushed,
         // so a marker here ends the discard at once.
         if (flush) begin
            occ_d   = 2'd0;
            state_d = marker_in ? (enable ? S_RUN : S_IDLE) : S_FLUSH;
         end
      end

      if (rd_rst) fifo_rdreq = 1'b0;
      inflight_d = fifo_rdreq;
   end

   always_ff @(posedge rdclk) begin
      if (rd_rst) begin
         state_q    <= S_IDLE;
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         buf0_q     <= '0;
         buf1_q     <= '0;
         eop_q      <= '0;
         eep_q      <= '0;
      end else begin
         state_q    <= state_d;
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
         eop_q      <= eop_d;
         eep_q      <= eep_d;
      end
   end

   assign eop_count = eop_q;
   assign eep_count = eep_q;
   assign busy      = (state_q != S_IDLE) || (occ_q != 2'd0) || inflight_q;

endmodule

// File: tb/tb_spw_tx_fifo_reader.sv
// Testbench for spw_tx_fifo_reader. A queue models the FIFO (data returned
// one cycle after an accepted pop); the expected transfer stream is the
// sequence of N-Chars written to the FIFO minus packets removed by flush,
// and marker counts are taken from that stream modulo 2^CNT_SIZE.
module tb_spw_tx_fifo_reader;
   localparam int DW = 9;
   localparam int CW = 2;

   logic          rdclk = 1'b0;
   logic          rd_rst, enable, flush, fifo_rdempty, fifo_rdreq;
   logic          tx_valid, tx_ready, busy;
   logic [DW-1:0] fifo_q, tx_data;
   logic [CW-1:0] eop_count, eep_count;

   spw_tx_fifo_reader #(.DATA_SIZE(DW), .CNT_SIZE(CW)) dut (
      .rdclk(rdclk), .rd_rst(rd_rst), .enable(enable), .flush(flush),
      .fifo_q(fifo_q), .fifo_rdempty(fifo_rdempty), .fifo_rdreq(fifo_rdreq),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .eop_count(eop_count), .eep_count(eep_count), .busy(busy)
   );

   always #5 rdclk = ~rdclk;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] fifo_mem[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] obs_q[$];
   int            n_reads = 0;
   int            n_xfers = 0;
   int            rd_viol = 0;
   logic          rd_s = 1'b0;
   int            model_eop = 0;
   int            model_eep = 0;

   // Monitor: one sample per cycle, mid-cycle.
   always @(negedge rdclk) begin
      rd_s = fifo_rdreq;
      if (fifo_rdreq && fifo_rdempty) rd_viol++;
      if (tx_valid && tx_ready) begin
         obs_q.push_back(tx_data);
         n_xfers++;
      end
   end

   // Advance to just after the next rising edge; the FIFO model answers an
   // accepted pop with its data valid for the whole following cycle.
   task automatic next_cycle();
      @(posedge rdclk);
      #1;
      if (rd_s) begin
         n_reads++;
         if (fifo_mem.size() > 0) fifo_q = fifo_mem.pop_front();
      end
      fifo_rdempty = (fifo_mem.size() == 0);
   endtask

   task automatic push(input logic [DW-1:0] d, input bit expect_out);
      fifo_mem.push_back(d);
      fifo_rdempty = 1'b0;
      if (expect_out) exp_q.push_back(d);
   endtask

   task automatic retire_expected();
      foreach (exp_q[i]) begin
         if (exp_q[i] == 9'h100) model_eop++;
         if (exp_q[i] == 9'h101) model_eep++;
      end
      exp_q.delete();
   endtask

   task automatic drain(input string name);
      int quiet = 0;
      int k;
      tx_ready = 1'b1;
      enable   = 1'b1;
      for (k = 0; k < 300 && quiet < 3; k++) begin
         @(negedge rdclk); #1;
         if (fifo_rdempty && !tx_valid && !fifo_rdreq) quiet++;
         else quiet = 0;
         next_cycle();
      end
      checks++;
      if (quiet < 3) begin
         errors++;
         $display("FAIL %s drain timeout: got quiet=%0d want 3", name, quiet);
      end
   endtask

   task automatic do_reset();
      rd_rst = 1'b1; enable = 1'b0; flush = 1'b0; tx_ready = 1'b0;
      repeat (3) next_cycle();
      rd_rst = 1'b0;
      fifo_mem.delete();
      fifo_rdempty = 1'b1;
      exp_q.delete();
      model_eop = 0;
      model_eep = 0;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         @(negedge rdclk); #1;
         checks++; if (tx_valid !== 1'b0) begin errors++;
            $display("FAIL reset_tx_valid: got %0b want 0", tx_valid); end
         checks++; if (tx_data !== 9'h000) begin errors++;
            $display("FAIL reset_tx_data: got %h want 000", tx_data); end
         checks++; if (eop_count !== 2'd0) begin errors++;
            $display("FAIL reset_eop: got %0d want 0", eop_count); end
         checks++; if (eep_count !== 2'd0) begin errors++;
            $display("FAIL reset_eep: got %0d want 0", eep_count); end
         checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %0b want 0", busy); end
         checks++; if (fifo_rdreq !== 1'b0) begin errors++;
            $display("FAIL reset_rdreq: got %0b want 0", fifo_rdreq); end
         if (k < 2) next_cycle();
      end
      next_cycle();
      rd_rst = 1'b0; enable = 1'b0;
      fifo_mem.delete();
      fifo_rdempty = 1'b1;
      next_cycle();
      @(negedge rdclk); #1;
      checks++; if (n_reads !== 0) begin errors++;
         $display("FAIL reset_reads: got %0d want 0", n_reads); end
      checks++; if (busy !== 1'b0) begin errors++;
         $display("FAIL reset_idle_busy: got %0b want 0", busy); end
      next_cycle();
   endtask

   task automatic test_single();
      int n_rq = 0, n_v = 0, rq_cyc = -1, v_cyc = -1;
      logic [DW-1:0] v_data = '0;
      push(9'h0A5, 1'b1);
      enable = 1'b1; tx_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge rdclk); #1;
         if (fifo_rdreq) begin n_rq++; rq_cyc = k; end
         if (tx_valid) begin n_v++; v_cyc = k; v_data = tx_data; end
         next_cycle();
      end
      checks++; if (n_rq != 1) begin errors++;
         $display("FAIL single_rdreq_pulses: got %0d want 1", n_rq); end
      checks++; if (n_v != 1) begin errors++;
         $display("FAIL single_valid_cycles: got %0d want 1", n_v); end
      checks++; if (v_cyc - rq_cyc != 2) begin errors++;
         $display("FAIL single_latency: got %0d want 2", v_cyc - rq_cyc); end
      checks++; if (v_data !== 9'h0A5) begin errors++;
         $display("FAIL single_data: got %h want 0a5", v_data); end
      checks++; if (eop_count !== 2'd0 || eep_count !== 2'd0) begin errors++;
         $display("FAIL single_counts: got %0d/%0d want 0/0", eop_count, eep_count); end
      retire_expected();
   endtask

   task automatic test_stream();
      int base = obs_q.size();
      int first = -1, last = -1, n = 0;
      for (int i = 1; i <= 7; i++) push(9'(i), 1'b1);
      push(9'h100, 1'b1);
      tx_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(negedge rdclk); #1;
         if (obs_q.size() - base > n) begin
            n = obs_q.size() - base;
            if (first < 0) first = k;
            last = k;
         end
         next_cycle();
      end
      checks++; if (n != 8) begin errors++;
         $display("FAIL stream_count: got %0d want 8", n); end
      checks++; if (last - first != 7) begin errors++;
         $display("FAIL stream_back_to_back: got span %0d want 7", last - first); end
      for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
         checks++; if (obs_q[base+i] !== exp_q[i]) begin errors++;
            $display("FAIL stream_data[%0d]: got %h want %h", i, obs_q[base+i], exp_q[i]); end
      end
      retire_expected();
      checks++; if (eop_count !== CW'(model_eop)) begin errors++;
         $display("FAIL stream_eop: got %0d want %0d", eop_count, CW'(model_eop)); end
   endtask

   task automatic test_backpressure();
      int base = obs_q.size();
      logic [DW-1:0] held = '0;
      for (int i = 0; i < 12; i++) push(9'h040 + 9'(i), 1'b1);
      tx_ready = 1'b1;
      repeat (4) begin
         @(negedge rdclk); #1;
         next_cycle();
      end
      tx_ready = 1'b0;
      for (int j = 0; j < 5; j++) begin
         @(negedge rdclk); #1;
         checks++; if (n_reads - n_xfers > 2 || n_reads < n_xfers) begin errors++;
            $display("FAIL bp_outstanding: got %0d want 0..2", n_reads - n_xfers); end
         if (j == 1) held = tx_data;
         if (j >= 1) begin
            checks++; if (fifo_rdreq !== 1'b0) begin errors++;
               $display("FAIL bp_rdreq: got %0b want 0", fifo_rdreq); end
            checks++; if (tx_valid !== 1'b1 || tx_data !== held) begin errors++;
               $display("FAIL bp_hold: got %0b/%h want 1/%h", tx_valid, tx_data, held); end
         end
         next_cycle();
      end
      drain("bp");
      checks++; if (obs_q.size() - base != exp_q.size()) begin errors++;
         $display("FAIL bp_count: got %0d want %0d", obs_q.size() - base, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
         checks++; if (obs_q[base+i] !== exp_q[i]) begin errors++;
            $display("FAIL bp_data[%0d]: got %h want %h", i, obs_q[base+i], exp_q[i]); end
      end
      retire_expected();
   endtask

   task automatic test_flush();
      int base = obs_q.size();
      bit seen = 1'b0;
      tx_ready = 1'b0; enable = 1'b1;
      push(9'h011, 1'b0);
      push(9'h022, 1'b0);
      push(9'h101, 1'b0);
      push(9'h033, 1'b1);
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge rdclk); #1;
         if (tx_valid) seen = 1'b1;
         else next_cycle();
      end
      checks++; if (!seen) begin errors++;
         $display("FAIL flush_wait_valid: got 0 want 1"); end
      next_cycle();
      flush = 1'b1;
      next_cycle();
      flush = 1'b0;
      @(negedge rdclk); #1;
      checks++; if (tx_valid !== 1'b0) begin errors++;
         $display("FAIL flush_valid_drop: got %0b want 0", tx_valid); end
      next_cycle();
      drain("flush");
      checks++; if (obs_q.size() - base != 1) begin errors++;
         $display("FAIL flush_count: got %0d want 1", obs_q.size() - base); end
      if (obs_q.size() > base) begin
         checks++; if (obs_q[base] !== 9'h033) begin errors++;
            $display("FAIL flush_next: got %h want 033", obs_q[base]); end
      end
      retire_expected();
      checks++; if (eep_count !== CW'(model_eep)) begin errors++;
         $display("FAIL flush_eep: got %0d want %0d", eep_count, CW'(model_eep)); end
   endtask

   task automatic test_random();
      int base = obs_q.size();
      logic [DW-1:0] d;
      for (int k = 0; k < 400; k++) begin
         enable   = ($urandom_range(0, 7) != 0);
         tx_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1 && fifo_mem.size() < 16) begin
            case ($urandom_range(0, 15))
               0:       d = 9'h100;
               1:       d = 9'h101;
               default: d = 9'($urandom_range(0, 511));
            endcase
            push(d, 1'b1);
         end
         @(negedge rdclk); #1;
         next_cycle();
      end
      drain("random");
      checks++; if (obs_q.size() - base != exp_q.size()) begin errors++;
         $display("FAIL rnd_count: got %0d want %0d", obs_q.size() - base, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
         checks++; if (obs_q[base+i] !== exp_q[i]) begin errors++;
            $display("FAIL rnd_data[%0d]: got %h want %h", i, obs_q[base+i], exp_q[i]); end
      end
      retire_expected();
      checks++; if (eop_count !== CW'(model_eop) || eep_count !== CW'(model_eep)) begin
         errors++;
         $display("FAIL rnd_counts: got %0d/%0d want %0d/%0d",
                  eop_count, eep_count, CW'(model_eop), CW'(model_eep)); end
      checks++; if (rd_viol != 0) begin errors++;
         $display("FAIL rdreq_while_empty: got %0d want 0", rd_viol); end
   endtask

   task automatic test_wrap();
      int base;
      do_reset();
      base = obs_q.size();
      for (int i = 0; i < 9; i++) push((i % 2 == 0) ? 9'h100 : 9'h101, 1'b1);
      drain("wrap");
      checks++; if (obs_q.size() - base != 9) begin errors++;
         $display("FAIL wrap_count: got %0d want 9", obs_q.size() - base); end
      checks++; if (eop_count !== 2'd1) begin errors++;
         $display("FAIL wrap_eop: got %0d want 1", eop_count); end
      checks++; if (eep_count !== 2'd0) begin errors++;
         $display("FAIL wrap_eep: got %0d want 0", eep_count); end
      retire_expected();
   endtask

   initial begin
      rd_rst = 1'b1; enable = 1'b1; flush = 1'b0; tx_ready = 1'b1;
      fifo_q = '0; fifo_rdempty = 1'b1;
      push(9'h055, 1'b0);
      push(9'h100, 1'b0);
      push(9'h0AA, 1'b0);
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_flush();
      test_random();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
